in_channel: RTL and testbench

- Input channel buffer feeding the zero VM's `in` and `inSize` instructions.
- A loader pushes words through a valid/ready handshake. The VM pops one word per `in` request and reads `in_size` for `inSize`.
- Replaces the preloaded inMem array and inMemPos counter with a real FIFO that can be loaded while the program runs.

---
 rtl/zero_pkg.sv | 8 +
 rtl/in_channel_mem.sv | 26 ++
 rtl/in_channel.sv | 67 ++++++
 tb/tb_in_channel.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/zero_pkg.sv
// zero_pkg: shared word type and width helpers for the zero VM and its channels
package zero_pkg;
  localparam int MemoryElementWidth = 12;
  typedef logic [MemoryElementWidth-1:0] word_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/in_channel_mem.sv
// in_channel_mem: NIn-word register array with one write port and a registered read port
module in_channel_mem
  import zero_pkg::*;
#(
  parameter int W  = MemoryElementWidth,
  parameter int N  = 2,
  parameter int AW = ptr_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [N];
  // storage is deliberately not reset; contents are don't-care until written
  always_ff @(posedge clock)
    if (we) mem[wa] <= wd;
  // read register holds its value unless a word is popped
  always_ff @(posedge clock or negedge reset)
    if (!reset) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/in_channel.sv
// in_channel: input FIFO feeding the VM in/inSize instructions with a loader handshake
module in_channel
  import zero_pkg::*;
#(
  parameter int MemoryElementWidth = zero_pkg::MemoryElementWidth,
  parameter int NIn = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          load_valid,
  input  logic [MemoryElementWidth-1:0] load_data,
  output logic                          load_ready,
  input  logic                          in_req,
  output logic                          in_ack,
  output logic                          in_ok,
  output logic [MemoryElementWidth-1:0] in_data,
  output logic [MemoryElementWidth-1:0] in_size,
  output logic [MemoryElementWidth-1:0] in_pos,
  output logic                          underflow
);
  localparam int PW = ptr_w(NIn);
  localparam int CW = $clog2(NIn + 1);
  logic [CW-1:0] count;
  logic [PW-1:0] wr, rd;
  logic push, pop;
  assign load_ready = count < CW'(NIn);
  assign push = load_valid && load_ready && !flush;
  assign pop = in_req && (count != '0) && !flush;
  assign in_size = MemoryElementWidth'(count);
  // pointer/count/flag state; flush overrides any coincident push or pop
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      wr <= '0;
      rd <= '0;
      in_pos <= '0;
      in_ack <= 1'b0;
      in_ok <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      count <= '0;
      wr <= '0;
      rd <= '0;
      in_pos <= '0;
      in_ack <= 1'b0;
      in_ok <= 1'b0;
    end else begin
      in_ack <= in_req;
      in_ok <= pop;
      if (in_req && count == '0) underflow <= 1'b1;
      if (push) wr <= (wr == PW'(NIn - 1)) ? '0 : wr + 1'b1;
      if (pop) rd <= (rd == PW'(NIn - 1)) ? '0 : rd + 1'b1;
      if (pop) in_pos <= in_pos + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  in_channel_mem #(.W(MemoryElementWidth), .N(NIn), .AW(PW)) u_mem (
    .clock(clock),
    .reset(reset),
    .we(push),
    .wa(wr),
    .wd(load_data),
    .re(pop),
    .ra(rd),
    .rd(in_data)
  );
endmodule

// File: tb/tb_in_channel.sv
// tb_in_channel: randomized and directed checks of in_channel (NIn=2 and NIn=3) against a queue model
module tb_in_channel;
  logic clock = 1'b0, reset = 1'b0, flush = 1'b0, load_valid = 1'b0, in_req = 1'b0;
  logic [11:0] load_data = '0;
  logic a_lr, a_ack, a_ok, a_uf, b_lr, b_ack, b_ok, b_uf;
  logic [11:0] a_data, a_size, a_pos, b_data, b_size, b_pos;
  int n_cmp = 0, n_err = 0;
  logic [11:0] mq [2][$];
  int md [2] = '{2, 3};
  logic e_ack [2], e_ok [2], e_uf [2];
  logic [11:0] e_data [2], e_pos [2];
  logic [11:0] seen [$];

  always #5 clock = ~clock;

  in_channel #(.MemoryElementWidth(12), .NIn(2)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_lr), .in_req(in_req), .in_ack(a_ack), .in_ok(a_ok), .in_data(a_data),
    .in_size(a_size), .in_pos(a_pos), .underflow(a_uf));
  in_channel #(.MemoryElementWidth(12), .NIn(3)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_lr), .in_req(in_req), .in_ack(b_ack), .in_ok(b_ok), .in_data(b_data),
    .in_size(b_size), .in_pos(b_pos), .underflow(b_uf));

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      e_ack[k] = 0; e_ok[k] = 0; e_uf[k] = 0; e_data[k] = '0; e_pos[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit room;
      room = mq[k].size() < md[k];
      if (flush) begin
        mq[k].delete();
        e_pos[k] = '0; e_ack[k] = 0; e_ok[k] = 0;
      end else begin
        e_ack[k] = in_req;
        e_ok[k] = 0;
        if (in_req) begin
          if (mq[k].size() > 0) begin
            e_data[k] = mq[k].pop_front();
            e_ok[k] = 1;
            e_pos[k] = e_pos[k] + 12'd1;
          end else e_uf[k] = 1;
        end
        if (load_valid && room) mq[k].push_back(load_data);
      end
    end
  endtask

  task automatic check_inst(input int k, input string p, input logic lr, input logic ack, input logic ok,
                            input logic [11:0] data, input logic [11:0] size, input logic [11:0] pos,
                            input logic uf);
    chk({p, ".load_ready"}, 12'(lr), 12'(mq[k].size() < md[k]));
    chk({p, ".in_ack"}, 12'(ack), 12'(e_ack[k]));
    if (e_ack[k]) chk({p, ".in_ok"}, 12'(ok), 12'(e_ok[k]));
    chk({p, ".in_data"}, data, e_data[k]);
    chk({p, ".in_size"}, size, 12'(mq[k].size()));
    chk({p, ".in_pos"}, pos, e_pos[k]);
    chk({p, ".underflow"}, 12'(uf), 12'(e_uf[k]));
  endtask

  task automatic check_all();
    check_inst(0, "a", a_lr, a_ack, a_ok, a_data, a_size, a_pos, a_uf);
    check_inst(1, "b", b_lr, b_ack, b_ok, b_data, b_size, b_pos, b_uf);
  endtask

  task automatic cycle(input logic lv, input logic [11:0] ld, input logic rq, input logic fl);
    load_valid = lv; load_data = ld; in_req = rq; flush = fl;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
    load_valid = 0; in_req = 0; flush = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1;
    cycle(1, 88, 0, 0);
    chk("push1.size", a_size, 1);
    cycle(1, 44, 0, 0);
    chk("push2.size", a_size, 2);
    chk("push2.full", 12'(a_lr), 0);
    cycle(0, 0, 1, 0);
    chk("pop1.data", a_data, 88);
    cycle(0, 0, 1, 0);
    chk("pop2.data", a_data, 44);
    cycle(0, 0, 1, 0);
    chk("pop3.ok", 12'(a_ok), 0);
    chk("pop3.held", a_data, 44);
    chk("pop3.uf", 12'(a_uf), 1);
    chk("pop3.pos", a_pos, 2);
    cycle(1, 88, 0, 0);
    cycle(1, 44, 0, 0);
    seen.delete();
    seen.push_back(a_size);
    cycle(0, 0, 1, 0); seen.push_back(a_data);
    seen.push_back(a_size);
    cycle(0, 0, 1, 0); seen.push_back(a_data);
    seen.push_back(a_size);
    chk("vm.s0", seen[0], 2); chk("vm.i0", seen[1], 88); chk("vm.s1", seen[2], 1);
    chk("vm.i1", seen[3], 44); chk("vm.s2", seen[4], 0);
    cycle(1, 88, 0, 0);
    cycle(1, 44, 0, 0);
    cycle(1, 99, 1, 0);
    chk("fullboth.data", a_data, 88);
    chk("fullboth.size", a_size, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 55, 1, 0);
    chk("emptyboth.ok", 12'(a_ok), 0);
    chk("emptyboth.size", a_size, 1);
    cycle(0, 0, 1, 1);
    chk("flush.ack", 12'(a_ack), 0);
    chk("flush.size", a_size, 0);
    chk("flush.pos", a_pos, 0);
    chk("flush.uf", 12'(a_uf), 1);
    seen.delete();
    for (int i = 1; i <= 3; i++) cycle(1, 12'(i), 0, 0);
    for (int i = 0; i < 2; i++) begin cycle(0, 0, 1, 0); seen.push_back(b_data); end
    cycle(1, 4, 0, 0);
    cycle(1, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin cycle(0, 0, 1, 0); seen.push_back(b_data); end
    for (int i = 0; i < 5; i++) chk($sformatf("wrap%0d", i), seen[i], 12'(i + 1));
    cycle(1, 77, 0, 0);
    #2 reset = 0;
    #1;
    model_reset();
    chk("arst.size", b_size, 0);
    chk("arst.data", b_data, 0);
    chk("arst.uf", 12'(b_uf), 0);
    check_all();
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
